// File: rtl/ceyloniac_fetch.sv
// Instruction fetch stage: issues single-outstanding reads to instruction RAM at the current PC,
// buffers returned words for decode, and drives PC increment / branch redirect.
module ceyloniac_fetch #(
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int INSTR_WIDTH    = 32,
  parameter int BUF_DEPTH      = 2
) (
  input  logic                      clk,
  input  logic                      fetch_reset,
  input  logic                      fetch_enable,
  input  logic [RAM_ADDR_WIDTH-1:0] pc_out,
  output logic                      pc_write,
  output logic [RAM_ADDR_WIDTH-1:0] pc_in,
  output logic                      imem_req,
  output logic [RAM_ADDR_WIDTH-1:0] imem_addr,
  input  logic                      imem_ready,
  input  logic                      imem_rvalid,
  input  logic [INSTR_WIDTH-1:0]    imem_rdata,
  input  logic                      branch_taken,
  input  logic [RAM_ADDR_WIDTH-1:0] branch_target,
  output logic                      instr_valid,
  output logic [INSTR_WIDTH-1:0]    instr_data,
  output logic [RAM_ADDR_WIDTH-1:0] instr_pc,
  input  logic                      instr_ready
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DROP
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [RAM_ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [RAM_ADDR_WIDTH-1:0] buf_pc_q   [BUF_DEPTH];
  logic [RAM_ADDR_WIDTH-1:0] buf_pc_d   [BUF_DEPTH];
  logic [INSTR_WIDTH-1:0]    buf_data_q [BUF_DEPTH];
  logic [INSTR_WIDTH-1:0]    buf_data_d [BUF_DEPTH];

  logic not_full;
  logic accept;
  logic push;
  logic pop;

  assign not_full = (count_q < CNT_W'(BUF_DEPTH));
  assign accept   = imem_req & imem_ready;
  // A branch squashes both the returning word and any same-cycle consumption.
  assign push     = (state_q == ST_WAIT) & imem_rvalid & ~branch_taken;
  assign pop      = instr_valid & instr_ready & ~branch_taken;

  always_ff @(posedge clk or negedge fetch_reset) begin
    if (!fetch_reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      req_pc_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc_q[i]   <= '0;
        buf_data_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      req_pc_q <= req_pc_d;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc_q[i]   <= buf_pc_d[i];
        buf_data_q[i] <= buf_data_d[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fetch_enable) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (accept)            state_d = branch_taken ? ST_DROP : ST_WAIT;
        else if (!fetch_enable) state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (branch_taken)     state_d = imem_rvalid ? ST_REQ : ST_DROP;
        else if (imem_rvalid) state_d = fetch_enable ? ST_REQ : ST_IDLE;
      end
      ST_DROP: begin
        if (imem_rvalid) state_d = (fetch_enable || branch_taken) ? ST_REQ : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state_q == ST_REQ) & not_full;
    imem_addr   = (state_q == ST_REQ) ? pc_out : '0;
    pc_write    = fetch_reset & (accept | branch_taken);
    pc_in       = '0;
    if (pc_write) pc_in = branch_taken ? branch_target : pc_out + RAM_ADDR_WIDTH'(1);
    instr_valid = (count_q != '0);
    instr_data  = instr_valid ? buf_data_q[rd_ptr_q] : '0;
    instr_pc    = instr_valid ? buf_pc_q[rd_ptr_q] : '0;
  end

  always_comb begin
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    req_pc_d   = accept ? pc_out : req_pc_q;
    buf_pc_d   = buf_pc_q;
    buf_data_d = buf_data_q;
    if (branch_taken) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        buf_pc_d[wr_ptr_q]   = req_pc_q;
        buf_data_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ceyloniac_fetch.sv
// Directed bench for ceyloniac_fetch: hand-sequenced RAM/PC behaviour, with a scoreboard
// queue of expected buffer entries checked by an independent monitor on every consumption.
module tb_ceyloniac_fetch;

  logic        clk;
  logic        fetch_reset;
  logic        fetch_enable;
  logic [15:0] pc_out;
  logic        pc_write;
  logic [15:0] pc_in;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [15:0] instr_pc;
  logic        instr_ready;

  typedef struct {
    logic [15:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  ceyloniac_fetch #(
    .RAM_ADDR_WIDTH(16),
    .INSTR_WIDTH   (32),
    .BUF_DEPTH     (2)
  ) dut (
    .clk          (clk),
    .fetch_reset  (fetch_reset),
    .fetch_enable (fetch_enable),
    .pc_out       (pc_out),
    .pc_write     (pc_write),
    .pc_in        (pc_in),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .instr_valid  (instr_valid),
    .instr_data   (instr_data),
    .instr_pc     (instr_pc),
    .instr_ready  (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the PC register feeding this stage.
  always @(posedge clk or negedge fetch_reset) begin
    if (!fetch_reset)  pc_out <= '0;
    else if (pc_write) pc_out <= pc_in;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] pc, input logic [31:0] data);
    exp_t e;
    e.pc   = pc;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Consumption happens at the next rising edge when valid&ready and no branch.
  always @(negedge clk) begin
    exp_t e;
    if (fetch_reset && instr_valid && instr_ready && !branch_taken) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_pop actual_pc=0x%0h actual_data=0x%0h expected=none",
                 instr_pc, instr_data);
      end else begin
        e = exp_q.pop_front();
        check_output("pop_pc", 32'(instr_pc), 32'(e.pc));
        check_output("pop_data", instr_data, e.data);
      end
    end
  end

  initial begin
    fetch_reset   = 1'b0;
    fetch_enable  = 1'b0;
    imem_ready    = 1'b0;
    imem_rvalid   = 1'b0;
    imem_rdata    = '0;
    branch_taken  = 1'b0;
    branch_target = '0;
    instr_ready   = 1'b0;

    repeat (2) tick();
    #1;
    check_output("rst_instr_valid", 32'(instr_valid), 0);
    check_output("rst_imem_req", 32'(imem_req), 0);
    check_output("rst_pc_write", 32'(pc_write), 0);

    // First fetch from PC 0
    fetch_reset  = 1'b1;
    fetch_enable = 1'b1;
    imem_ready   = 1'b1;
    #1;
    check_output("idle_req", 32'(imem_req), 0);
    tick();
    #1;
    check_output("f0_req", 32'(imem_req), 1);
    check_output("f0_addr", 32'(imem_addr), 32'h0000);
    check_output("f0_pc_write", 32'(pc_write), 1);
    check_output("f0_pc_in", 32'(pc_in), 32'h0001);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hA000_0001;
    push_exp(16'h0000, 32'hA000_0001);
    #1;
    check_output("wait_req", 32'(imem_req), 0);
    check_output("wait_pc_write", 32'(pc_write), 0);
    tick();
    imem_rvalid = 1'b0;
    #1;
    check_output("f0_instr_valid", 32'(instr_valid), 1);
    check_output("f0_instr_pc", 32'(instr_pc), 32'h0000);
    check_output("f1_addr", 32'(imem_addr), 32'h0001);
    check_output("f1_pc_in", 32'(pc_in), 32'h0002);

    // Fill buffer with decode stalled
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hA000_0002;
    push_exp(16'h0001, 32'hA000_0002);
    tick();
    imem_rvalid = 1'b0;
    #1;
    check_output("full_req", 32'(imem_req), 0);
    check_output("full_pc_write", 32'(pc_write), 0);
    tick();
    #1;
    check_output("full_req_hold", 32'(imem_req), 0);
    instr_ready = 1'b1;
    tick();
    #1;
    check_output("resume_req", 32'(imem_req), 1);
    check_output("resume_addr", 32'(imem_addr), 32'h0002);
    check_output("resume_pc_in", 32'(pc_in), 32'h0003);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hA000_0003;
    push_exp(16'h0002, 32'hA000_0003);
    #1;
    check_output("drained_valid", 32'(instr_valid), 0);
    tick();
    imem_rvalid  = 1'b0;
    imem_ready   = 1'b0;
    fetch_enable = 1'b0;
    tick();
    #1;
    check_output("idle_valid", 32'(instr_valid), 0);
    check_output("idle_req2", 32'(imem_req), 0);

    // PC wrap at 0xFFFF
    instr_ready   = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 16'hFFFF;
    #1;
    check_output("idle_br_pc_write", 32'(pc_write), 1);
    check_output("idle_br_pc_in", 32'(pc_in), 32'hFFFF);
    tick();
    branch_taken = 1'b0;
    fetch_enable = 1'b1;
    imem_ready   = 1'b1;
    tick();
    #1;
    check_output("wrap_addr", 32'(imem_addr), 32'hFFFF);
    check_output("wrap_pc_in", 32'(pc_in), 32'h0000);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hB000_FFFF;
    push_exp(16'hFFFF, 32'hB000_FFFF);
    tick();
    imem_rvalid = 1'b0;
    #1;
    check_output("wrap_instr_pc", 32'(instr_pc), 32'hFFFF);
    check_output("post_wrap_addr", 32'(imem_addr), 32'h0000);

    // Branch in WAIT with one buffered entry
    tick();
    branch_taken  = 1'b1;
    branch_target = 16'h0100;
    exp_q.delete();
    #1;
    check_output("wbr_pc_write", 32'(pc_write), 1);
    check_output("wbr_pc_in", 32'(pc_in), 32'h0100);
    check_output("wbr_req", 32'(imem_req), 0);
    tick();
    branch_taken = 1'b0;
    imem_rvalid  = 1'b1;
    imem_rdata   = 32'hDEAD_BEEF;
    instr_ready  = 1'b1;
    #1;
    check_output("wbr_flushed", 32'(instr_valid), 0);
    tick();
    imem_rvalid = 1'b0;
    #1;
    check_output("wbr_req_after", 32'(imem_req), 1);
    check_output("wbr_addr_after", 32'(imem_addr), 32'h0100);
    check_output("wbr_pc_in_after", 32'(pc_in), 32'h0101);
    check_output("wbr_drop_valid", 32'(instr_valid), 0);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hA000_0100;
    push_exp(16'h0100, 32'hA000_0100);
    tick();
    imem_rvalid = 1'b0;
    imem_ready  = 1'b0;
    #1;
    check_output("wbr_instr_pc", 32'(instr_pc), 32'h0100);

    // Branch in the same cycle as acceptance
    tick();
    imem_ready    = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 16'h0200;
    exp_q.delete();
    #1;
    check_output("abr_req", 32'(imem_req), 1);
    check_output("abr_pc_write", 32'(pc_write), 1);
    check_output("abr_pc_in", 32'(pc_in), 32'h0200);
    tick();
    branch_taken = 1'b0;
    imem_rvalid  = 1'b1;
    imem_rdata   = 32'h1111_1111;
    #1;
    check_output("abr_drop_req", 32'(imem_req), 0);
    tick();
    imem_rvalid = 1'b0;
    #1;
    check_output("abr_no_valid", 32'(instr_valid), 0);
    check_output("abr_addr", 32'(imem_addr), 32'h0200);
    check_output("abr_next_pc_in", 32'(pc_in), 32'h0201);

    // Reset while waiting with one buffered entry
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hA000_0200;
    push_exp(16'h0200, 32'hA000_0200);
    instr_ready = 1'b0;
    tick();
    imem_rvalid = 1'b0;
    #1;
    check_output("rwait_addr", 32'(imem_addr), 32'h0201);
    tick();
    #1;
    check_output("rwait_valid", 32'(instr_valid), 1);
    fetch_reset   = 1'b0;
    imem_ready    = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 16'h0300;
    exp_q.delete();
    #1;
    check_output("ar_instr_valid", 32'(instr_valid), 0);
    check_output("ar_instr_pc", 32'(instr_pc), 0);
    check_output("ar_instr_data", instr_data, 0);
    check_output("ar_imem_req", 32'(imem_req), 0);
    check_output("ar_imem_addr", 32'(imem_addr), 0);
    check_output("ar_pc_write", 32'(pc_write), 0);
    check_output("ar_pc_in", 32'(pc_in), 0);
    branch_taken = 1'b0;
    tick();
    tick();
    fetch_reset  = 1'b1;
    fetch_enable = 1'b0;
    imem_rvalid  = 1'b1;
    imem_rdata   = 32'h2222_2222;
    instr_ready  = 1'b1;
    #1;
    check_output("late_rv_req", 32'(imem_req), 0);
    tick();
    imem_rvalid = 1'b0;
    #1;
    check_output("late_rv_valid", 32'(instr_valid), 0);
    tick();
    #1;
    check_output("late_rv_valid2", 32'(instr_valid), 0);

    check_output("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
